// File: rtl/mux_arbiter_4_if.sv
// Request/data/handshake bundle for mux_arbiter_4.
// The lock lines exist only when ARB_LOCK_EN is defined.
interface mux_arbiter_4_if #(
  parameter int unsigned DATA_W = 32
);
  logic [3:0]        req;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [DATA_W-1:0] data4;
`ifdef ARB_LOCK_EN
  logic [3:0]        lock;
`endif
  logic [3:0]        ack;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;

  // Requesters and the downstream consumer.
  modport master (
    output req, data1, data2, data3, data4,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output out_ready,
    input  ack, out_valid, out_data, out_src
  );

  // The arbiter itself.
  modport slave (
    input  req, data1, data2, data3, data4,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  out_ready,
    output ack, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_arbiter_4.sv
// Round-robin arbiter and capture register for the shared 4:1 result mux.
// Define ARB_LOCK_EN to let the last winner hold the grant via its lock line.
module mux_arbiter_4 #(
  parameter int unsigned DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  mux_arbiter_4_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        src_q, src_d;
  logic [3:0]        ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [1:0]        win;
  logic [1:0]        idx;
  logic              found;
  logic [DATA_W-1:0] win_data;
  logic              any_req;

  assign any_req = |bus.req;

  // Winner: first set request scanning last+1 .. last+4 (wrapping mod 4).
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef ARB_LOCK_EN
    if (bus.req[last_q] && bus.lock[last_q]) begin
      win = last_q;
    end
`endif
  end

  always_comb begin
    unique case (win)
      2'd0:    win_data = bus.data1;
      2'd1:    win_data = bus.data2;
      2'd2:    win_data = bus.data3;
      default: win_data = bus.data4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StBusy;
      StBusy:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    src_d   = src_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          last_d     = win;
          src_d      = win;
          data_d     = win_data;
          valid_d    = 1'b1;
          ack_d[win] = 1'b1;
        end
      end
      StBusy: begin
        if (bus.out_ready) valid_d = 1'b0;
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 2'b11;
      src_q   <= 2'b00;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 4'b0000;
    end else begin
      last_q  <= last_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Randomized and directed bench for mux_arbiter_4 against a cycle-level reference model.
module tb_mux_arbiter_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_arbiter_4_if #(.DATA_W(32)) bus ();

  mux_arbiter_4 #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int          m_last;
  bit          m_busy;
  logic        exp_valid;
  logic [3:0]  exp_ack;
  logic [31:0] exp_data;
  logic [1:0]  exp_src;
  logic [31:0] d [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last    = 3;
    m_busy    = 1'b0;
    exp_valid = 1'b0;
    exp_ack   = 4'b0000;
    exp_data  = 32'h0;
    exp_src   = 2'b00;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"}, {31'h0, bus.out_valid}, {31'h0, exp_valid});
    check_eq({tag, ".ack"},   {28'h0, bus.ack},       {28'h0, exp_ack});
    check_eq({tag, ".data"},  bus.out_data,           exp_data);
    check_eq({tag, ".src"},   {30'h0, bus.out_src},   {30'h0, exp_src});
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic step(input string tag, input logic [3:0] r, input logic rdy,
                      input logic [3:0] lk);
    int  w;
    bit  found;
    bus.req       = r;
    bus.out_ready = rdy;
    bus.data1     = d[0];
    bus.data2     = d[1];
    bus.data3     = d[2];
    bus.data4     = d[3];
`ifdef ARB_LOCK_EN
    bus.lock      = lk;
`endif
    exp_ack = 4'b0000;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        w     = m_last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && r[(m_last + k) % 4]) begin
            w     = (m_last + k) % 4;
            found = 1'b1;
          end
        end
`ifdef ARB_LOCK_EN
        if (r[m_last] && lk[m_last]) w = m_last;
`else
        if (lk != 4'b0000) w = w;
`endif
        m_last     = w;
        m_busy     = 1'b1;
        exp_valid  = 1'b1;
        exp_ack[w] = 1'b1;
        exp_data   = d[w];
        exp_src    = 2'(w);
      end
    end else if (rdy) begin
      m_busy    = 1'b0;
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [3:0] r;
    logic       rdy;
    model_reset();
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 32'h1111_1111 * (i + 1);
    bus.data1 = d[0];
    bus.data2 = d[1];
    bus.data3 = d[2];
    bus.data4 = d[3];
`ifdef ARB_LOCK_EN
    bus.lock = 4'b0000;
`endif
    @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) step("idle", 4'b0000, 1'b1, 4'b0000);

    // All requesting, consumer always ready: strict rotation, one transfer per 2 cycles.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) d[j] = $urandom;
      step("rr", 4'b1111, 1'b1, 4'b0000);
    end

    // Backpressure: captured word frozen until out_ready.
    step("drain", 4'b0000, 1'b1, 4'b0000);
    d[2] = 32'hDEAD_BEEF;
    step("bp_cap", 4'b0100, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) d[j] = $urandom;
      step("bp_hold", 4'b1111, 1'b0, 4'b0000);
    end
    check_eq("bp_data", bus.out_data, 32'hDEAD_BEEF);
    step("bp_hs", 4'b0000, 1'b1, 4'b0000);
    step("bp_idle", 4'b0000, 1'b1, 4'b0000);

    // Wrap-around: after grant to 1, req=0011 goes to 0.
    step("wrap_g1", 4'b0010, 1'b1, 4'b0000);
    step("wrap_hs", 4'b0000, 1'b1, 4'b0000);
    step("wrap_g0", 4'b0011, 1'b1, 4'b0000);
    check_eq("wrap_ack", {28'h0, bus.ack}, 32'h1);

    // Reset while BUSY with backpressure.
    step("rb_hs", 4'b0000, 1'b1, 4'b0000);
    step("rb_cap", 4'b0100, 1'b0, 4'b0000);
    step("rb_hold", 4'b0100, 1'b0, 4'b0000);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rb_async");
    @(posedge clk);
    #1;
    check_outputs("rb_held");
    rst = 1'b0;
    step("rb_first", 4'b1001, 1'b1, 4'b0000);
    check_eq("rb_first_src", {30'h0, bus.out_src}, 32'h0);
    step("rb_hs2", 4'b0000, 1'b1, 4'b0000);

`ifdef ARB_LOCK_EN
    // Locked requester 1 keeps the grant; releasing lock hands over to 3.
    step("lk_g", 4'b0010, 1'b1, 4'b0000);
    step("lk_hs", 4'b0000, 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) step("lk_hold", 4'b1010, 1'b1, 4'b0010);
    step("lk_rel", 4'b1010, 1'b1, 4'b0000);
    step("lk_rel", 4'b1010, 1'b1, 4'b0000);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) d[j] = $urandom;
      r   = 4'($urandom);
      rdy = ($urandom_range(0, 9) < 7);
      step("rand", r, rdy, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
